// File: rtl/mem_bus_ctrl.sv
// SRAM-style memory bus responder with programmable wait states.
// Optional MEM_BUS_EXT_WAIT_EN adds an external active-low wait input.
module mem_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_stall,
  output logic        o_err,
  output logic [15:0] o_bus_addr,
  output logic [15:0] o_bus_wdata,
  input  logic [15:0] i_bus_rdata,
`ifdef MEM_BUS_EXT_WAIT_EN
  input  logic        i_bus_wait_n,
`endif
  output logic        o_bus_cs_n,
  output logic        o_bus_oe_n,
  output logic        o_bus_we_n
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic        w_req;
  logic        w_acc_done;

  assign w_req = i_mem_rd | i_mem_wr;

`ifdef MEM_BUS_EXT_WAIT_EN
  assign w_acc_done = (r_cnt == 4'd0) & i_bus_wait_n;
`else
  assign w_acc_done = (r_cnt == 4'd0);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_req) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_acc_done) w_next = S_HOLD;
      S_HOLD:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_stall = ((r_state == S_IDLE) & w_req) |
                   (r_state == S_SETUP) |
                   (r_state == S_ACCESS) |
                   (r_state == S_HOLD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      o_rdata     <= 16'd0;
      o_err       <= 1'b0;
      o_bus_addr  <= 16'd0;
      o_bus_wdata <= 16'd0;
      o_bus_cs_n  <= 1'b1;
      o_bus_oe_n  <= 1'b1;
      o_bus_we_n  <= 1'b1;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_req) begin
        o_bus_addr  <= i_addr;
        o_bus_wdata <= i_wdata;
        r_wr        <= i_mem_wr;
        o_err       <= i_mem_rd & i_mem_wr;
      end
      if (r_state == S_SETUP)
        r_cnt <= LP_WAIT;
      else if ((r_state == S_ACCESS) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;
      if ((r_state == S_ACCESS) && w_acc_done && !r_wr)
        o_rdata <= i_bus_rdata;
      // strobes follow the state being entered
      o_bus_cs_n <= !((w_next == S_SETUP) ||
                      (w_next == S_ACCESS) ||
                      (w_next == S_HOLD));
      o_bus_oe_n <= !((w_next == S_ACCESS) && !r_wr);
      o_bus_we_n <= !((w_next == S_ACCESS) && r_wr);
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with WAIT_CYCLES=0,
// one with WAIT_CYCLES=1.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] brd;
  logic        wait_n;
  logic [15:0] rdata [2];
  logic [15:0] baddr [2];
  logic [15:0] bwdata [2];
  logic        stall [2];
  logic        err [2];
  logic        cs [2];
  logic        oe [2];
  logic        we [2];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_rd(rd[0]), .i_mem_wr(wr[0]),
    .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata[0]), .o_stall(stall[0]), .o_err(err[0]),
    .o_bus_addr(baddr[0]), .o_bus_wdata(bwdata[0]),
    .i_bus_rdata(brd),
`ifdef MEM_BUS_EXT_WAIT_EN
    .i_bus_wait_n(wait_n),
`endif
    .o_bus_cs_n(cs[0]), .o_bus_oe_n(oe[0]), .o_bus_we_n(we[0])
  );

  mem_bus_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_rd(rd[1]), .i_mem_wr(wr[1]),
    .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata[1]), .o_stall(stall[1]), .o_err(err[1]),
    .o_bus_addr(baddr[1]), .o_bus_wdata(bwdata[1]),
    .i_bus_rdata(brd),
`ifdef MEM_BUS_EXT_WAIT_EN
    .i_bus_wait_n(1'b1),
`endif
    .o_bus_cs_n(cs[1]), .o_bus_oe_n(oe[1]), .o_bus_we_n(we[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one request and watches it until stall drops (DONE).
  task automatic txn(input int d, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] rdv, input int nwait,
                     output int ns, output int noe, output int nwe,
                     output logic [15:0] sa, output logic [15:0] swd,
                     output logic se);
    bit fin = 0;
    bit seen = 0;
    ns = 0; noe = 0; nwe = 0;
    sa = 16'hxxxx; swd = 16'hxxxx; se = 1'bx;
    @(negedge clk);
    addr = a; wdata = wd;
    brd = (nwait > 0) ? 16'hDEAD : rdv;
    wait_n = (nwait > 0) ? 1'b0 : 1'b1;
    rd[d] = r; wr[d] = w;
    for (int k = 0; k < 40 && !fin; k++) begin
      #1;
      if (!stall[d]) fin = 1;
      else begin
        ns++;
        if (!cs[d] && !seen) begin
          seen = 1; sa = baddr[d]; se = err[d];
        end
        if (!oe[d]) begin
          noe++;
          if (nwait > 0 && noe == nwait + 1) begin
            wait_n = 1'b1; brd = rdv;
          end
        end
        if (!we[d]) begin
          nwe++; swd = bwdata[d];
        end
        @(negedge clk);
      end
    end
    chk("done_stall", 32'(stall[d]), 0);
    chk("done_cs_n", 32'(cs[d]), 1);
    rd[d] = 1'b0; wr[d] = 1'b0; wait_n = 1'b1;
  endtask

  int ns, noe, nwe;
  logic [15:0] sa, swd;
  logic se;

  initial begin
    rd[0] = 0; rd[1] = 0; wr[0] = 0; wr[1] = 0;
    addr = 0; wdata = 0; brd = 0; wait_n = 1;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall[1]), 0);
    chk("rst_cs_n", 32'(cs[1]), 1);
    chk("rst_rdata", 32'(rdata[1]), 0);
    chk("rst_baddr", 32'(baddr[1]), 0);
    rst_n = 1'b1;

    // read, WAIT_CYCLES=1
    txn(1, 1, 0, 16'h1234, 16'h0, 16'hBEEF, 0, ns, noe, nwe, sa, swd, se);
    chk("t1_stall", ns, 5);
    chk("t1_oe", noe, 2);
    chk("t1_we", nwe, 0);
    chk("t1_addr", 32'(sa), 32'h1234);
    chk("t1_err", 32'(se), 0);
    chk("t1_rdata", 32'(rdata[1]), 32'hBEEF);

    // prior read on the WAIT_CYCLES=0 unit
    txn(0, 1, 0, 16'h0010, 16'h0, 16'h5A5A, 0, ns, noe, nwe, sa, swd, se);
    chk("t0_stall", ns, 4);
    chk("t0_oe", noe, 1);
    chk("t0_rdata", 32'(rdata[0]), 32'h5A5A);

    // write, WAIT_CYCLES=0
    txn(0, 0, 1, 16'h00F0, 16'hA55A, 16'h0, 0, ns, noe, nwe, sa, swd, se);
    chk("t2_stall", ns, 4);
    chk("t2_we", nwe, 1);
    chk("t2_oe", noe, 0);
    chk("t2_wdata", 32'(swd), 32'hA55A);
    chk("t2_addr", 32'(sa), 32'h00F0);
    chk("t2_rdata", 32'(rdata[0]), 32'h5A5A);

    // rd and wr together: write wins, err flagged
    txn(0, 1, 1, 16'h0002, 16'h0001, 16'h0, 0, ns, noe, nwe, sa, swd, se);
    chk("t3_we", nwe, 1);
    chk("t3_oe", noe, 0);
    chk("t3_wdata", 32'(swd), 32'h0001);
    chk("t3_err_setup", 32'(se), 1);
    repeat (3) @(negedge clk);
    chk("t3_err_hold", 32'(err[0]), 1);

    // back-to-back reads
    txn(0, 1, 0, 16'h0004, 16'h0, 16'h1111, 0, ns, noe, nwe, sa, swd, se);
    chk("t4a_stall", ns, 4);
    chk("t4a_err", 32'(err[0]), 0);
    chk("t4a_rdata", 32'(rdata[0]), 32'h1111);
    txn(0, 1, 0, 16'h0003, 16'h0, 16'h2222, 0, ns, noe, nwe, sa, swd, se);
    chk("t4b_stall", ns, 4);
    chk("t4b_addr", 32'(sa), 32'h0003);
    chk("t4b_rdata", 32'(rdata[0]), 32'h2222);

    // async reset during ACCESS of a write
    @(negedge clk);
    addr = 16'h0040; wdata = 16'h7777; wr[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_we_pre", 32'(we[1]), 0);
    wr[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_we", 32'(we[1]), 1);
    chk("t5_cs", 32'(cs[1]), 1);
    chk("t5_oe", 32'(oe[1]), 1);
    chk("t5_rdata", 32'(rdata[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_stall", 32'(stall[1]), 0);
    chk("t5_cs_idle", 32'(cs[1]), 1);

`ifdef MEM_BUS_EXT_WAIT_EN
    txn(0, 1, 0, 16'h0050, 16'h0, 16'hC0DE, 3, ns, noe, nwe, sa, swd, se);
    chk("t6_oe", noe, 4);
    chk("t6_stall", ns, 7);
    chk("t6_rdata", 32'(rdata[0]), 32'hC0DE);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
